// File: rtl/sram_ctrl.sv
// sram_ctrl: sequenced wait-state controller between the b16 memory bus and a
// 16-bit asynchronous SRAM. All SRAM strobes, address and write data are registered.
// Optional build macro: SRAM_CTRL_WAIT_SW_EN adds the wait_cfg port, which replaces
// the WAIT parameter as the source of the access pulse length.
module sram_ctrl #(
    parameter  int unsigned WAIT = 3,
    localparam int unsigned DW   = 16,
    localparam int unsigned AW   = 18,
    localparam int unsigned BW   = 3,
    localparam int unsigned CW   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sel,
    input  logic [DW-1:0] addr,
    input  logic [BW-1:0] bank,
    input  logic          r,
    input  logic [1:0]    w,
    input  logic [DW-1:0] dwrite,
`ifdef SRAM_CTRL_WAIT_SW_EN
    input  logic [CW-1:0] wait_cfg,
`endif
    output logic [DW-1:0] rdata,
    output logic          ready,
    output logic [AW-1:0] sram_addr,
    input  logic [DW-1:0] sram_dq_in,
    output logic [DW-1:0] sram_dq_out,
    output logic          sram_dq_oe,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WS   = 3'd2,
        S_WP   = 3'd3,
        S_WH   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_rdata;
    logic [AW-1:0] r_sram_addr;
    logic [DW-1:0] r_dq_out;
    logic          r_dq_oe;
    logic          r_ce_n;
    logic          r_oe_n;
    logic          r_we_n;
    logic          r_ub_n;
    logic          r_lb_n;

    logic          w_req;
    logic          w_rd;
    logic          w_wr;
    logic [CW-1:0] w_cnt_load;
    logic          w_addr_lsb_unused;

    // Request decode: a read wins when r and w are both set.
    assign w_req = sel & (r | (|w));
    assign w_rd  = sel & r;
    assign w_wr  = sel & ~r & (|w);

    // Byte address bit 0 does not reach the word-wide SRAM.
    assign w_addr_lsb_unused = addr[0];

`ifdef SRAM_CTRL_WAIT_SW_EN
    // Run-time wait count; a value of 0 behaves as 1.
    assign w_cnt_load = (wait_cfg == '0) ? '0 : wait_cfg - CW'(1);
`else
    // Wait count fixed at elaboration: 0 behaves as 1, saturated to the counter range.
    localparam int unsigned WAIT_EFF = (WAIT == 0) ? 1 : ((WAIT > 15) ? 15 : WAIT);
    assign w_cnt_load = CW'(WAIT_EFF - 1);
`endif

    // Bus handshake: free to advance when idle with nothing pending, or on completion.
    assign ready = ~reset & (((r_state == S_IDLE) & ~w_req) | (r_state == S_DONE));

    // Access sequencer; strobes change on the same edge as the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rd) begin
                        r_state     <= S_RD;
                        r_cnt       <= w_cnt_load;
                        r_sram_addr <= {bank, addr[DW-1:1]};
                        r_ce_n      <= 1'b0;
                        r_oe_n      <= 1'b0;
                        r_we_n      <= 1'b1;
                        r_ub_n      <= 1'b0;
                        r_lb_n      <= 1'b0;
                        r_dq_oe     <= 1'b0;
                    end else if (w_wr) begin
                        r_state     <= S_WS;
                        r_cnt       <= w_cnt_load;
                        r_sram_addr <= {bank, addr[DW-1:1]};
                        r_dq_out    <= dwrite;
                        r_ce_n      <= 1'b0;
                        r_oe_n      <= 1'b1;
                        r_we_n      <= 1'b1;
                        r_ub_n      <= ~w[1];
                        r_lb_n      <= ~w[0];
                        r_dq_oe     <= 1'b1;
                    end
                end
                S_RD: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_rdata <= sram_dq_in;
                        r_state <= S_DONE;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_ub_n  <= 1'b1;
                        r_lb_n  <= 1'b1;
                    end
                end
                S_WS: begin
                    r_state <= S_WP;
                    r_we_n  <= 1'b0;
                end
                S_WP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_state <= S_WH;
                        r_we_n  <= 1'b1;
                    end
                end
                S_WH: begin
                    r_state <= S_DONE;
                    r_ce_n  <= 1'b1;
                    r_ub_n  <= 1'b1;
                    r_lb_n  <= 1'b1;
                    r_dq_oe <= 1'b0;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_dq_oe <= 1'b0;
                    r_ce_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                    r_ub_n  <= 1'b1;
                    r_lb_n  <= 1'b1;
                end
            endcase
        end
    end

    assign rdata       = r_rdata;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_ce_n   = r_ce_n;
    assign sram_oe_n   = r_oe_n;
    assign sram_we_n   = r_we_n;
    assign sram_ub_n   = r_ub_n;
    assign sram_lb_n   = r_lb_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed plus randomized bench for sram_ctrl with an SRAM device model
// and a word-level reference memory.
module tb_sram_ctrl;

    localparam int unsigned TB_WAIT = 3;
    localparam logic [5:0]  IDLE_S  = 6'b111110;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [15:0] addr;
    logic [2:0]  bank;
    logic        r;
    logic [1:0]  w;
    logic [15:0] dwrite;
    logic [15:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_in = 16'hDEAD;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    int n_chk  = 0;
    int n_pass = 0;
    logic [15:0] last_rd;

    logic [15:0] dev     [logic [17:0]];
    logic [15:0] ref_mem [logic [17:0]];

    sram_ctrl #(.WAIT(TB_WAIT)) dut (
        .clk(clk),
        .reset(reset),
        .sel(sel),
        .addr(addr),
        .bank(bank),
        .r(r),
        .w(w),
        .dwrite(dwrite),
`ifdef SRAM_CTRL_WAIT_SW_EN
        .wait_cfg(4'(TB_WAIT)),
`endif
        .rdata(rdata),
        .ready(ready),
        .sram_addr(sram_addr),
        .sram_dq_in(sram_dq_in),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe),
        .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dev_rd(input logic [17:0] k);
        return dev.exists(k) ? dev[k] : 16'hDEAD;
    endfunction

    // Asynchronous SRAM device: writes while CE and WE are low, drives data while OE is low.
    always @(negedge clk) begin
        logic [15:0] t;
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            t = dev_rd(sram_addr);
            if (!sram_ub_n) t[15:8] = sram_dq_out[15:8];
            if (!sram_lb_n) t[7:0]  = sram_dq_out[7:0];
            dev[sram_addr] = t;
        end
        sram_dq_in = (!sram_ce_n && !sram_oe_n) ? dev_rd(sram_addr) : 16'hDEAD;
    end

    function automatic logic [5:0] strb();
        return {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic idle_cycles(input int n);
        sel = 1'b0; r = 1'b0; w = 2'b00;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_bus", {25'd0, ready, strb()}, {25'd0, 1'b1, IDLE_S});
        end
    endtask

    // One access, checked cycle by cycle against the documented timing; returns in DONE.
    task automatic access(input bit from_done, input logic rr, input logic [1:0] ww,
                          input logic [15:0] a, input logic [2:0] b, input logic [15:0] d);
        logic [17:0] key;
        logic [15:0] exp_rd;
        logic [5:0]  exp_s;
        logic        exp_rdy;
        int          last;
        key  = {b, a[15:1]};
        last = rr ? TB_WAIT + 1 : TB_WAIT + 3;
        exp_rd = ref_mem.exists(key) ? ref_mem[key] : 16'hDEAD;
        sel = 1'b1; r = rr; w = ww; addr = a; bank = b; dwrite = d;
        if (from_done) @(negedge clk);
        else #1;
        chk("req_cycle", {25'd0, ready, strb()}, {25'd0, 1'b0, IDLE_S});
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            exp_rdy = 1'b0;
            if (n == last) begin
                exp_s = IDLE_S; exp_rdy = 1'b1;
            end else if (rr) begin
                exp_s = 6'b001000;
            end else if (n == 1 || n == TB_WAIT + 2) begin
                exp_s = {1'b0, 1'b1, 1'b1, ~ww[1], ~ww[0], 1'b1};
            end else begin
                exp_s = {1'b0, 1'b1, 1'b0, ~ww[1], ~ww[0], 1'b1};
            end
            chk(rr ? "rd_cycle" : "wr_cycle", {25'd0, ready, strb()}, {25'd0, exp_rdy, exp_s});
            if (n < last) chk("sram_addr", 32'(sram_addr), 32'(key));
            if (!rr && n < last) chk("dq_out", 32'(sram_dq_out), 32'(d));
        end
        if (rr) begin
            chk("rdata", 32'(rdata), 32'(exp_rd));
            last_rd = exp_rd;
        end else begin
            chk("rdata_hold", 32'(rdata), 32'(last_rd));
            if (ww[1]) exp_rd[15:8] = d[15:8];
            if (ww[0]) exp_rd[7:0]  = d[7:0];
            ref_mem[key] = exp_rd;
        end
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] a;
        logic [2:0]  b;
        logic [1:0]  ww;
        logic        rr;
        bit          b2b;

        for (int bi = 0; bi < 2; bi++) begin
            for (int wi = 0; wi < 8; wi++) begin
                v = 16'($urandom);
                dev[{3'(bi), 15'(wi)}]     = v;
                ref_mem[{3'(bi), 15'(wi)}] = v;
            end
        end
        dev[18'h0091A] = 16'hBEEF; ref_mem[18'h0091A] = 16'hBEEF;
        dev[18'h28080] = 16'h1111; ref_mem[18'h28080] = 16'h1111;
        dev[18'h00008] = 16'h2222; ref_mem[18'h00008] = 16'h2222;

        reset = 1'b1; sel = 1'b0; addr = '0; bank = '0; r = 1'b0; w = 2'b00; dwrite = '0;
        last_rd = 16'h0000;
        repeat (2) @(negedge clk);
        chk("reset_bus", {25'd0, ready, strb()}, {25'd0, 1'b0, IDLE_S});
        chk("reset_rdata", 32'(rdata), 32'h0);
        chk("reset_addr", 32'(sram_addr), 32'h0);
        chk("reset_dq_out", 32'(sram_dq_out), 32'h0);
        reset = 1'b0;
        #1;
        chk("post_reset_ready", 32'(ready), 32'h1);

        // Read 0x1234 from bank 0.
        access(0, 1'b1, 2'b00, 16'h1234, 3'd0, 16'h0000);
        idle_cycles(1);
        // High-byte write into bank 5.
        access(0, 1'b0, 2'b10, 16'h0100, 3'd5, 16'hA55A);
        idle_cycles(1);
        access(0, 1'b1, 2'b00, 16'h0100, 3'd5, 16'h0000);
        chk("hi_byte_merge", 32'(rdata), 32'h0000A511);
        // Back-to-back write then read of the same word.
        idle_cycles(1);
        access(0, 1'b0, 2'b11, 16'h0010, 3'd0, 16'h1357);
        access(1, 1'b1, 2'b00, 16'h0010, 3'd0, 16'h0000);
        chk("b2b_readback", 32'(rdata), 32'h00001357);

        // Unselected requests are ignored.
        sel = 1'b0; r = 1'b1; w = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("unsel_read", {25'd0, ready, strb()}, {25'd0, 1'b1, IDLE_S});
        end
        r = 1'b0; w = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("unsel_write", {25'd0, ready, strb()}, {25'd0, 1'b1, IDLE_S});
        end

        // Reset in the second write-pulse cycle; data equals current contents.
        sel = 1'b1; r = 1'b0; w = 2'b11; addr = 16'h0010; bank = 3'd0; dwrite = ref_mem[18'h00008];
        repeat (3) @(negedge clk);
        chk("pulse_before_reset", {26'd0, strb()}, {26'd0, 6'b010001});
        reset = 1'b1; sel = 1'b0; w = 2'b00;
        #1;
        chk("ready_in_reset", 32'(ready), 32'h0);
        @(negedge clk);
        chk("midreset_bus", {26'd0, strb()}, {26'd0, IDLE_S});
        chk("midreset_rdata", 32'(rdata), 32'h0);
        chk("midreset_addr", 32'(sram_addr), 32'h0);
        reset = 1'b0;
        last_rd = 16'h0000;
        #1;
        chk("midreset_ready", 32'(ready), 32'h1);
        access(0, 1'b1, 2'b00, 16'h1234, 3'd0, 16'h0000);

        // Randomized traffic over a small set of words.
        for (int i = 0; i < 40; i++) begin
            b2b = 1'($urandom_range(0, 1));
            if (!b2b) idle_cycles(int'($urandom_range(1, 2)));
            b  = 3'($urandom_range(0, 1));
            a  = {12'h000, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            case ($urandom_range(0, 2))
                0: begin rr = 1'b1; ww = 2'b00; end
                1: begin rr = 1'b0; ww = 2'($urandom_range(1, 3)); end
                default: begin rr = 1'b1; ww = 2'($urandom_range(1, 3)); end
            endcase
            access(b2b, rr, ww, a, b, 16'($urandom));
        end
        idle_cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Wait-state controller between the b16 CPU/debugger memory bus and the external 16-bit asynchronous SRAM. It replaces the free-running READY counter with a sequenced read/write engine:
- registered, glitch-free SRAM strobes;
- byte-lane writes;
- a single `ready` handshake that the top level ANDs into the CPU `run` enable.

It sits directly downstream of the address decoder (the `sel[0]` region) and upstream of the SRAM pins and the read-data mux.

## Interface
Parameters:
- `WAIT`, default 3: access pulse length in clocks; 0 is treated as 1.

Ports:
- `clk`  in  1  system clock (CLOCK_50).
- `reset`  in  1  synchronous, active-high reset.
- `sel`  in  1  SRAM region selected by the address decoder.
- `addr`  in  16  CPU byte address; bit 0 ignored.
- `bank`  in  3  upper SRAM address bits.
- `r`  in  1  read request.
- `w`  in  2  byte write enables: [1] high byte, [0] low byte.
- `dwrite`  in  16  write data.
- `rdata`  out  16  registered read data, valid when `ready`.
- `ready`  out  1  bus may advance.
- `sram_addr`  out  18  `{bank, addr[15:1]}`, registered.
- `sram_dq_in`  in  16  SRAM data pins, input side.
- `sram_dq_out`  out  16  write data to the pins.
- `sram_dq_oe`  out  1  tristate enable for the data pins; the top level drives them.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  SRAM strobes, all registered.

## Operation
- `req = sel & (r | |w)`. If `r` and `w` are both set, the cycle is a read and `w` is ignored.
- States: IDLE, RD, WS (write setup), WP (write pulse), WH (write hold), DONE.
- IDLE
  - `req & r` → RD. Latch address and lanes; load `cnt = WAIT-1`.
  - `req & |w` → WS. Latch address, lanes and `dwrite`.
- RD
  - `ce_n=0`, `oe_n=0`, `ub_n=lb_n=0`.
  - While `cnt != 0`, decrement `cnt`.
  - At `cnt == 0`, capture `rdata <= sram_dq_in` and go to DONE.
- WS
  - `ce_n=0`, `we_n=1`, `dq_oe=1`, `ub_n=~w[1]`, `lb_n=~w[0]`.
  - → WP, loading `cnt = WAIT-1`.
- WP
  - `we_n=0`; everything else as WS.
  - Count down; at `cnt == 0` go to WH.
- WH
  - `we_n=1`; `ce_n`, `dq_oe`, address and lanes held.
  - → DONE.
- DONE
  - All strobes inactive (1), `dq_oe=0`.
  - → IDLE unconditionally.
- `ready = (IDLE & ~req) | DONE`. It is combinational from state and `req` only.
- Inputs may change at the clock edge where `ready` is sampled high.
- A request still present in the IDLE cycle after DONE starts a new access. Repeating a held request is permitted: reads are idempotent and writes rewrite the same data.
- `rdata` holds its value until the next read captures new data.
- Reset, including mid-access:
  - state is forced to IDLE;
  - all `*_n` outputs go to 1, `dq_oe=0`, `rdata=0`, `sram_addr=0`, `sram_dq_out=0`;
  - `ready=0` during the reset cycle.
  - A write interrupted by reset may leave its target word corrupt; this is accepted.

## Timing
- Counted from the edge that samples the request in IDLE:
  - read: `ready` is high `WAIT+1` cycles later;
  - write: `ready` is high `WAIT+3` cycles later.
- `sram_we_n` is low for exactly WAIT cycles. Address, data and `ce_n` are stable for one full cycle before `we_n` falls and one full cycle after it rises.
- `sram_oe_n` and `sram_we_n` are never low in the same cycle.
- Idle gap between back-to-back accesses: exactly one cycle (DONE), in which all strobes are high.
- `cnt` is 4 bits wide; WAIT above 15 saturates to 15.

## Configuration
- `SRAM_CTRL_WAIT_SW_EN` defined:
  - adds input port `wait_cfg` (4 bits);
  - the wait count is taken from `wait_cfg` when leaving IDLE, so changes take effect only on the next access;
  - 0 is treated as 1;
  - the `WAIT` parameter is unused.
- Not defined:
  - no `wait_cfg` port;
  - the wait count is the `WAIT` parameter constant.

## Test plan
- Read, WAIT=3: `sel=1`, `r=1`, `addr=0x1234`, `bank=0`, `sram_dq_in=0xBEEF` → `sram_addr=0x0091A`, `oe_n` low for 3 cycles, `ready` high on cycle 4, `rdata=0xBEEF`.
- High-byte write: `w=2'b10`, `dwrite=0xA55A`, `addr=0x0100`, `bank=5` → `sram_addr=0x28080`, `ub_n=0`, `lb_n=1`, `we_n` low for exactly 3 cycles, `dq_oe` high from WS through WH, `ready` high on cycle 6.
- Back-to-back write 0x0010 then read 0x0010 with the model echoing the write → exactly one DONE gap between accesses, `rdata=` the written word, `oe_n` and `we_n` never low together.
- `sel=0` with `r=1` or `w=2'b11` → `ready` stays high, all strobes stay 1, no state change.
- Reset asserted in the second WP cycle → the next cycle shows IDLE, `we_n=ce_n=1`, `dq_oe=0`, `rdata=0`; a fresh read then completes normally.
- With `SRAM_CTRL_WAIT_SW_EN`:
  - `wait_cfg=0` → `oe_n` low for 1 cycle, `ready` on cycle 2;
  - `wait_cfg` changed mid-read → the current read keeps its latched count.
